keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Drives the 4x3 matrix keypad of the microwave front panel and produces the one-hot 10-bit digit code consumed by the keypad encoder.
- Strobes one row at a time and samples the columns.
- Debounces press and release, rejects multi-key ghosting, and reports the special keys * and # separately.
- Sits between the panel pins and the encoder's `code` input.

Parameters:
- SCAN_DIV, 1000: clock cycles each row stays asserted (dwell). Columns are sampled on the last cycle of the dwell. Minimum 3.
- DEBOUNCE, 4: consecutive agreeing samples required to accept a press or a release. Minimum 1.

Ports:
- clk  input  1  system clock
- clear  input  1  synchronous active-high reset
- cols  input  3  column lines, active-high, pulled low externally, asynchronous to clk
- rows  output  4  row strobes, one-hot, active-high
- keypad  output  10  one-hot digit code, bit n = digit n; all-zero when no digit is held
- key_star  output  1  high while * is held (debounced)
- key_hash  output  1  high while # is held (debounced)
- key_valid  output  1  one-cycle pulse when a new key is accepted (digit, * or #)

Behaviour:
- One clock (`clk`). Reset is synchronous and active-high, on `clear`.
- Reset values while `clear` is high at a rising edge:
  - rows=4'b0001, keypad=0, key_star=0, key_hash=0, key_valid=0.
  - Dwell counter=0, state=SCAN, all debounce counters=0, both synchronizer stages cleared.
  - Applies in any state, including mid-debounce or mid-hold.
- Key map (row, col): (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4, (1,1)=5, (1,2)=6, (2,0)=7, (2,1)=8, (2,2)=9, (3,0)=*, (3,1)=0, (3,2)=#.
- cols pass through a 2-flop synchronizer; every sample uses the synchronized value.
- Dwell counter counts 0..SCAN_DIV-1 and wraps. A "sample" is the cycle where the counter equals SCAN_DIV-1.
- A sample is "single" when exactly one col bit is high, "none" when all are low, and "multi" otherwise.
- States:
  - SCAN: at each sample:
    - single → CHECK; latch row/col index; press count=1; rows do not advance.
    - none or multi → rows rotate left (0001→0010→0100→1000→0001).
  - CHECK: rows frozen. At each sample:
    - single on the latched col → count+1. When count reaches DEBOUNCE, go to HELD.
    - anything else → SCAN; count=0; rows advance.
    - DEBOUNCE=1 goes straight from SCAN to HELD on the first single sample.
  - HELD: rows frozen; outputs driven. At each sample:
    - latched col low, none sample → release count+1.
    - latched col high → release count=0. Other cols going high are ignored; no multi-key re-decode.
    - When release count reaches DEBOUNCE: go to SCAN, clear outputs, advance rows.
- Outputs are registered.
  - The entry into HELD and the key_valid pulse are visible on the cycle after the accepting sample.
  - keypad, key_star and key_hash are set on HELD entry and cleared on the cycle after the releasing sample.
- Exactly one of keypad, key_star or key_hash is nonzero in HELD; all are zero outside HELD.
- key_valid pulses once per accepted press. There is no autorepeat while held.

Test Plan (SCAN_DIV=4, DEBOUNCE=3; cycle 0 = first cycle after clear deasserts):
- Idle, cols=000 → rows cycles 0001,0010,0100,1000 with 4-cycle dwell and wraps at cycle 16; keypad=0 and key_valid=0 throughout.
- Key 5 held from reset (cols=010 whenever rows=0010):
  - Row1 sample at cycle 7; CHECK samples at cycles 11 and 15.
  - Cycle 16: keypad=10'b0000100000 and key_valid=1 for exactly that cycle.
  - rows stays 0010 while the key is held.
- Release key 5 after HELD entry → keypad drops to 0 one cycle after the 3rd consecutive low sample; rows then resumes from 0100.
- Bounce: key 8 toggles cols once during CHECK → return to SCAN with no key_valid. A later stable press is accepted with a single key_valid and keypad=10'b0100000000.
- Ghost: cols=011 on row 3 → treated as none and the scan continues. A stable # (cols=100 on row 3) → key_hash=1 and keypad=0.
- clear asserted while HELD with key_star=1 → next cycle key_star=0 and rows=0001, with no key_valid pulse.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: strobes rows, debounces press/release,
// rejects ghosting and emits a one-hot digit code plus * / # flags.
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 4
) (
   input  logic       clk,
   input  logic       clear,
   input  logic [2:0] cols,
   output logic [3:0] rows,
   output logic [9:0] keypad,
   output logic       key_star,
   output logic       key_hash,
   output logic       key_valid
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      CHECK = 2'd1,
      HELD  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    cols_s1_q;
   logic [2:0]    cols_s2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    rows_q, rows_d;
   logic [2:0]    col_q, col_d;
   logic [DW-1:0] press_q, press_d;
   logic [DW-1:0] rel_q, rel_d;
   logic [9:0]    keypad_q, keypad_d;
   logic          star_q, star_d;
   logic          hash_q, hash_d;
   logic          valid_q, valid_d;

   logic          sample;
   logic          is_none;
   logic          is_single;
   logic          accept;
   logic [3:0]    rows_adv;
   logic [1:0]    ri;
   logic [1:0]    ci;
   logic [3:0]    idx;
   logic [9:0]    dec_digit;
   logic          dec_star;
   logic          dec_hash;

   assign sample    = (cnt_q == DWELL_LAST);
   assign is_none   = (cols_s2_q == 3'b000);
   assign is_single = (cols_s2_q == 3'b001) ||
                      (cols_s2_q == 3'b010) ||
                      (cols_s2_q == 3'b100);
   assign rows_adv  = {rows_q[2:0], rows_q[3]};

   // Key decode from the current row strobe and synchronized column.
   always_comb begin
      ri = 2'd0;
      case (rows_q)
         4'b0010: ri = 2'd1;
         4'b0100: ri = 2'd2;
         4'b1000: ri = 2'd3;
         default: ri = 2'd0;
      endcase
      ci = 2'd0;
      case (cols_s2_q)
         3'b010:  ci = 2'd1;
         3'b100:  ci = 2'd2;
         default: ci = 2'd0;
      endcase
      idx       = 4'({2'b00, ri} * 4'd3) + {2'b00, ci} + 4'd1;
      dec_digit = '0;
      dec_star  = 1'b0;
      dec_hash  = 1'b0;
      if (ri == 2'd3) begin
         case (ci)
            2'd0:    dec_star = 1'b1;
            2'd1:    dec_digit = 10'd1;
            default: dec_hash = 1'b1;
         endcase
      end else begin
         dec_digit = 10'd1 << idx;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = sample ? '0 : cnt_q + CW'(1);
      rows_d   = rows_q;
      col_d    = col_q;
      press_d  = press_q;
      rel_d    = rel_q;
      keypad_d = keypad_q;
      star_d   = star_q;
      hash_d   = hash_q;
      valid_d  = 1'b0;
      accept   = 1'b0;
      case (state_q)
         SCAN: begin
            if (sample) begin
               if (is_single) begin
                  col_d = cols_s2_q;
                  if (DEBOUNCE == 1) begin
                     accept = 1'b1;
                  end else begin
                     state_d = CHECK;
                     press_d = DW'(1);
                  end
               end else begin
                  rows_d = rows_adv;
               end
            end
         end
         CHECK: begin
            if (sample) begin
               if (cols_s2_q == col_q) begin
                  if (press_q == DB_LAST) begin
                     accept = 1'b1;
                  end else begin
                     press_d = press_q + DW'(1);
                  end
               end else begin
                  state_d = SCAN;
                  press_d = '0;
                  rows_d  = rows_adv;
               end
            end
         end
         HELD: begin
            if (sample) begin
               if ((cols_s2_q & col_q) != 3'b000) begin
                  rel_d = '0;
               end else if (is_none) begin
                  if (rel_q == DB_LAST) begin
                     state_d  = SCAN;
                     rel_d    = '0;
                     rows_d   = rows_adv;
                     keypad_d = '0;
                     star_d   = 1'b0;
                     hash_d   = 1'b0;
                  end else begin
                     rel_d = rel_q + DW'(1);
                  end
               end else begin
                  rel_d = '0;
               end
            end
         end
         default: begin
            state_d = SCAN;
         end
      endcase
      // Accepted press: freeze on this row and publish the decoded key.
      if (accept) begin
         state_d  = HELD;
         press_d  = '0;
         rel_d    = '0;
         keypad_d = dec_digit;
         star_d   = dec_star;
         hash_d   = dec_hash;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q   <= SCAN;
         cols_s1_q <= '0;
         cols_s2_q <= '0;
         cnt_q     <= '0;
         rows_q    <= 4'b0001;
         col_q     <= '0;
         press_q   <= '0;
         rel_q     <= '0;
         keypad_q  <= '0;
         star_q    <= 1'b0;
         hash_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cols_s1_q <= cols;
         cols_s2_q <= cols_s1_q;
         cnt_q     <= cnt_d;
         rows_q    <= rows_d;
         col_q     <= col_d;
         press_q   <= press_d;
         rel_q     <= rel_d;
         keypad_q  <= keypad_d;
         star_q    <= star_d;
         hash_q    <= hash_d;
         valid_q   <= valid_d;
      end
   end

   assign rows      = rows_q;
   assign keypad    = keypad_q;
   assign key_star  = star_q;
   assign key_hash  = hash_q;
   assign key_valid = valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
// Cycle 0 is the first cycle after clear deasserts.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       clear = 1'b1;
   logic [2:0] cols;
   logic [3:0] rows;
   logic [9:0] keypad;
   logic       key_star;
   logic       key_hash;
   logic       key_valid;

   // Pressed key model: which row strobe connects to which column lines.
   logic [3:0] key_rows = 4'b0000;
   logic [2:0] key_cols = 3'b000;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int vcount = 0;
   int v0;

   assign cols = (|(rows & key_rows)) ? key_cols : 3'b000;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_valid === 1'b1) vcount++;
   end

   keypad_scanner #(
      .SCAN_DIV(4),
      .DEBOUNCE(3)
   ) dut (
      .clk(clk),
      .clear(clear),
      .cols(cols),
      .rows(rows),
      .keypad(keypad),
      .key_star(key_star),
      .key_hash(key_hash),
      .key_valid(key_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic do_reset();
      clear = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      clear = 1'b0;
      cyc = 0;
   endtask

   initial begin
      // Idle scan and reset values
      do_reset();
      chk("rst_rows", 32'(rows), 32'h1);
      chk("rst_keypad", 32'(keypad), 32'h0);
      chk("rst_star", 32'(key_star), 32'h0);
      chk("rst_hash", 32'(key_hash), 32'h0);
      chk("rst_valid", 32'(key_valid), 32'h0);
      for (int c = 0; c <= 16; c++) begin
         goto(c);
         chk("idle_rows", 32'(rows), 32'(4'b0001 << ((c / 4) % 4)));
         chk("idle_out", {21'd0, keypad, key_valid}, 32'h0);
      end

      // Key 5 held from reset
      key_rows = 4'b0010;
      key_cols = 3'b010;
      do_reset();
      v0 = vcount;
      goto(15);
      chk("k5_no_early", 32'(vcount - v0), 32'h0);
      chk("k5_keypad_c15", 32'(keypad), 32'h0);
      goto(16);
      chk("k5_keypad", 32'(keypad), 32'h020);
      chk("k5_valid", 32'(key_valid), 32'h1);
      chk("k5_rows", 32'(rows), 32'h2);
      goto(17);
      chk("k5_valid_1cyc", 32'(key_valid), 32'h0);
      chk("k5_keypad_c17", 32'(keypad), 32'h020);

      // Release key 5
      goto(20);
      chk("k5_rows_frozen", 32'(rows), 32'h2);
      key_rows = 4'b0000;
      goto(31);
      chk("rel_keypad_c31", 32'(keypad), 32'h020);
      chk("rel_no_repeat", 32'(vcount - v0), 32'h1);
      goto(32);
      chk("rel_keypad", 32'(keypad), 32'h0);
      chk("rel_rows", 32'(rows), 32'h4);
      chk("rel_valid", 32'(key_valid), 32'h0);
      goto(36);
      chk("rel_rows_next", 32'(rows), 32'h8);

      // Bounce on key 8 during CHECK, then a stable press
      key_rows = 4'b0100;
      key_cols = 3'b010;
      do_reset();
      v0 = vcount;
      goto(12);
      chk("b8_check_rows", 32'(rows), 32'h4);
      key_cols = 3'b000;
      goto(14);
      key_cols = 3'b010;
      goto(16);
      chk("b8_rescan_rows", 32'(rows), 32'h8);
      goto(39);
      chk("b8_no_valid", 32'(vcount - v0), 32'h0);
      goto(40);
      chk("b8_valid", 32'(key_valid), 32'h1);
      chk("b8_keypad", 32'(keypad), 32'h100);
      chk("b8_rows", 32'(rows), 32'h4);
      goto(41);
      chk("b8_one_pulse", 32'(vcount - v0), 32'h1);

      // Ghost on row 3, then a stable #
      key_rows = 4'b1000;
      key_cols = 3'b011;
      do_reset();
      v0 = vcount;
      goto(12);
      chk("gh_rows_r3", 32'(rows), 32'h8);
      goto(16);
      chk("gh_rows_wrap", 32'(rows), 32'h1);
      key_cols = 3'b100;
      goto(28);
      chk("gh_rows_r3b", 32'(rows), 32'h8);
      goto(39);
      chk("gh_no_valid", 32'(vcount - v0), 32'h0);
      chk("gh_hash_c39", 32'(key_hash), 32'h0);
      goto(40);
      chk("hash_flag", 32'(key_hash), 32'h1);
      chk("hash_keypad", 32'(keypad), 32'h0);
      chk("hash_star", 32'(key_star), 32'h0);
      chk("hash_valid", 32'(key_valid), 32'h1);

      // clear while * is held
      key_rows = 4'b1000;
      key_cols = 3'b001;
      do_reset();
      v0 = vcount;
      goto(24);
      chk("star_flag", 32'(key_star), 32'h1);
      chk("star_valid", 32'(key_valid), 32'h1);
      chk("star_keypad", 32'(keypad), 32'h0);
      goto(26);
      clear = 1'b1;
      @(posedge clk);
      #1;
      chk("clr_star", 32'(key_star), 32'h0);
      chk("clr_rows", 32'(rows), 32'h1);
      chk("clr_valid", 32'(key_valid), 32'h0);
      clear = 1'b0;
      cyc = 0;
      goto(2);
      chk("clr_pulses", 32'(vcount - v0), 32'h1);
      chk("clr_star_c2", 32'(key_star), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
